// File: rtl/wb_port_sequencer.sv
// Write-back sequencer: decodes each accepted instruction into 0..2 register writes and issues them one per cycle.
// Outputs are registered (write appears the cycle after transfer); popq stalls upstream one cycle to drain its second write.
module wb_port_sequencer #(
  parameter int RSP_ID = 4,
  parameter int RNONE  = 15,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic             cnd,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic [63:0]      valE,
  input  logic [63:0]      valM,
  output logic             wr_en,
  output logic [3:0]       wr_addr,
  output logic [63:0]      wr_data,
  output logic             halted,
  output logic             instr_err,
  output logic [CNT_W-1:0] wr_count
);

  localparam logic [3:0] RSP  = 4'(RSP_ID);
  localparam logic [3:0] NONE = 4'(RNONE);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, SECOND} state_t;

  state_t      state, state_n;
  logic [3:0]  pend_addr, pend_addr_n;
  logic [63:0] pend_data, pend_data_n;
  logic        wr_en_n;
  logic [3:0]  wr_addr_n;
  logic [63:0] wr_data_n;
  logic        halted_n, instr_err_n;

  logic        xfer;
  logic        w1_vld, w2_vld, set_halt, set_err;
  logic [3:0]  w1_addr;
  logic [63:0] w1_data;

  assign in_ready = (state == IDLE) && !halted && !instr_err;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    w1_vld   = 1'b0;
    w1_addr  = rB;
    w1_data  = valE;
    w2_vld   = 1'b0;
    set_halt = 1'b0;
    set_err  = 1'b0;
    case (icode)
      4'h0: set_halt = 1'b1;
      4'h2: w1_vld = cnd;
      4'h3, 4'h6: w1_vld = 1'b1;
      4'h5: begin
        w1_vld  = 1'b1;
        w1_addr = rA;
        w1_data = valM;
      end
      4'h8, 4'h9, 4'hA: begin
        w1_vld  = 1'b1;
        w1_addr = RSP;
      end
      4'hB: begin
        w1_vld  = 1'b1;
        w1_addr = RSP;
        w2_vld  = (rA != NONE);
      end
      4'hC, 4'hD, 4'hE, 4'hF: set_err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_n     = state;
    pend_addr_n = pend_addr;
    pend_data_n = pend_data;
    wr_en_n     = 1'b0;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;
    halted_n    = halted;
    instr_err_n = instr_err;
    if (state == SECOND) begin
      // The latched popq load result goes out after the %rsp update.
      wr_en_n   = 1'b1;
      wr_addr_n = pend_addr;
      wr_data_n = pend_data;
      state_n   = IDLE;
    end else if (xfer) begin
      if (w1_vld && (w1_addr != NONE)) begin
        wr_en_n   = 1'b1;
        wr_addr_n = w1_addr;
        wr_data_n = w1_data;
      end
      if (w2_vld) begin
        pend_addr_n = rA;
        pend_data_n = valM;
        state_n     = SECOND;
      end
      halted_n    = halted | set_halt;
      instr_err_n = instr_err | set_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pend_addr <= 4'd0;
      pend_data <= 64'd0;
      wr_en     <= 1'b0;
      wr_addr   <= 4'd0;
      wr_data   <= 64'd0;
      halted    <= 1'b0;
      instr_err <= 1'b0;
      wr_count  <= '0;
    end else begin
      state     <= state_n;
      pend_addr <= pend_addr_n;
      pend_data <= pend_data_n;
      wr_en     <= wr_en_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      halted    <= halted_n;
      instr_err <= instr_err_n;
      if (wr_en) wr_count <= wr_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_wb_port_sequencer.sv
// Bench for wb_port_sequencer: vector table, hand-written popq/halt/reset sequences, then random traffic vs a write-queue model.
module tb_wb_port_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  icode = 4'h1;
  logic        cnd = 1'b0;
  logic [3:0]  rA = 4'd0;
  logic [3:0]  rB = 4'd0;
  logic [63:0] valE = 64'd0;
  logic [63:0] valM = 64'd0;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic        halted;
  logic        instr_err;
  logic [31:0] wr_count;

  wb_port_sequencer #(.RSP_ID(4), .RNONE(15), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .cnd(cnd), .rA(rA), .rB(rB), .valE(valE), .valM(valM),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .halted(halted), .instr_err(instr_err), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Model: queue of writes, each tagged with the cycle it must appear in.
  typedef struct {
    logic [3:0]  a;
    logic [63:0] d;
    int          c;
  } wr_t;

  wr_t         q[$];
  int          cyc = 0;
  int          sec_cyc = -1;
  bit          mh = 1'b0;
  bit          me = 1'b0;
  logic [31:0] mcount = 32'd0;
  logic [3:0]  last_a = 4'd0;
  logic [63:0] last_d = 64'd0;
  int          n_chk = 0;
  int          n_err = 0;

  typedef struct {
    logic [3:0]  ic;
    logic        cn;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] ve;
    logic [63:0] vm;
    logic        ew;
    logic [3:0]  ea;
    logic [63:0] ed;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] pa, input logic [63:0] pd, input int pc);
    wr_t w;
    w.a = pa;
    w.d = pd;
    w.c = pc;
    if (pa != 4'd15) q.push_back(w);
  endtask

  task automatic model_accept(input logic [3:0] ic, input logic cn, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm);
    case (ic)
      4'h0: mh = 1'b1;
      4'h2: if (cn) push(rb, ve, cyc + 1);
      4'h3, 4'h6: push(rb, ve, cyc + 1);
      4'h5: push(ra, vm, cyc + 1);
      4'h8, 4'h9, 4'hA: push(4'd4, ve, cyc + 1);
      4'hB: begin
        push(4'd4, ve, cyc + 1);
        if (ra != 4'd15) begin
          push(ra, vm, cyc + 2);
          sec_cyc = cyc + 1;
        end
      end
      4'hC, 4'hD, 4'hE, 4'hF: me = 1'b1;
      default: ;
    endcase
  endtask

  // Called at a negedge: drive, predict, clock once, check at the next negedge.
  task automatic step(input logic v, input logic [3:0] ic, input logic cn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm);
    bit  exp_rdy;
    wr_t w;
    in_valid = v; icode = ic; cnd = cn; rA = ra; rB = rb; valE = ve; valM = vm;
    #1;
    exp_rdy = !mh && !me && (cyc != sec_cyc);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (v && exp_rdy) model_accept(ic, cn, ra, rb, ve, vm);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("halted", 64'(halted), 64'(mh));
    chk("instr_err", 64'(instr_err), 64'(me));
    chk("wr_count", 64'(wr_count), 64'(mcount));
    if (q.size() > 0 && q[0].c == cyc) begin
      w = q.pop_front();
      chk("wr_en", 64'(wr_en), 64'd1);
      chk("wr_addr", 64'(wr_addr), 64'(w.a));
      chk("wr_data", wr_data, w.d);
      last_a = w.a;
      last_d = w.d;
      mcount++;
    end else begin
      chk("wr_en_idle", 64'(wr_en), 64'd0);
      chk("wr_addr_hold", 64'(wr_addr), 64'(last_a));
      chk("wr_data_hold", wr_data, last_d);
    end
  endtask

  task automatic idle();
    step(1'b0, 4'h1, 1'b0, 4'd0, 4'd0, 64'd0, 64'd0);
  endtask

  // Asserts rst at the current time (mid-cycle), checks the async clear, releases before the next edge.
  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    q.delete();
    mh = 1'b0; me = 1'b0; mcount = 32'd0; last_a = 4'd0; last_d = 64'd0; sec_cyc = -1;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_wr_count", 64'(wr_count), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_instr_err", 64'(instr_err), 64'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  ric, rra, rrb;
    logic [63:0] rve, rvm;
    logic        rv, rcn;

    tbl[0]  = '{4'h3, 1'b0, 4'd0, 4'd2,  64'h11,   64'h0,  1'b1, 4'd2, 64'h11};
    tbl[1]  = '{4'h6, 1'b0, 4'd0, 4'd3,  64'h22,   64'h0,  1'b1, 4'd3, 64'h22};
    tbl[2]  = '{4'h5, 1'b0, 4'd5, 4'd0,  64'h0,    64'h33, 1'b1, 4'd5, 64'h33};
    tbl[3]  = '{4'h2, 1'b0, 4'd0, 4'd6,  64'h99,   64'h0,  1'b0, 4'd0, 64'h0};
    tbl[4]  = '{4'h2, 1'b1, 4'd0, 4'd6,  64'h99,   64'h0,  1'b1, 4'd6, 64'h99};
    tbl[5]  = '{4'h3, 1'b0, 4'd0, 4'd15, 64'h77,   64'h0,  1'b0, 4'd0, 64'h0};
    tbl[6]  = '{4'h8, 1'b0, 4'd1, 4'd2,  64'h1234, 64'h5,  1'b1, 4'd4, 64'h1234};
    tbl[7]  = '{4'h9, 1'b0, 4'd1, 4'd2,  64'h1240, 64'h5,  1'b1, 4'd4, 64'h1240};
    tbl[8]  = '{4'hA, 1'b0, 4'd1, 4'd2,  64'h1238, 64'h5,  1'b1, 4'd4, 64'h1238};
    tbl[9]  = '{4'h1, 1'b0, 4'd1, 4'd2,  64'h50,   64'h51, 1'b0, 4'd0, 64'h0};
    tbl[10] = '{4'h4, 1'b0, 4'd1, 4'd2,  64'h60,   64'h61, 1'b0, 4'd0, 64'h0};
    tbl[11] = '{4'h7, 1'b1, 4'd1, 4'd2,  64'h70,   64'h71, 1'b0, 4'd0, 64'h0};
    tbl[12] = '{4'hB, 1'b0, 4'd15, 4'd0, 64'h3000, 64'hEE, 1'b1, 4'd4, 64'h3000};

    do_reset();
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Vectors streamed back to back with in_valid held high.
    for (int i = 0; i < 13; i++) begin
      step(1'b1, tbl[i].ic, tbl[i].cn, tbl[i].ra, tbl[i].rb, tbl[i].ve, tbl[i].vm);
      chk("tbl_wr_en", 64'(wr_en), 64'(tbl[i].ew));
      if (tbl[i].ew) begin
        chk("tbl_wr_addr", 64'(wr_addr), 64'(tbl[i].ea));
        chk("tbl_wr_data", wr_data, tbl[i].ed);
      end
      if (i == 3) chk("cnt_after_stream", 64'(wr_count), 64'd3);
    end
    chk("popq_rnone_no_stall", 64'(in_ready), 64'd1);

    // popq to rA=7: stall one cycle, then the held instruction is taken.
    step(1'b1, 4'hB, 1'b0, 4'd7, 4'd0, 64'h1008, 64'hABCD);
    chk("popq_w1", {wr_addr, wr_data[59:0]}, {4'd4, 60'h1008});
    chk("popq_stall", 64'(in_ready), 64'd0);
    step(1'b1, 4'h3, 1'b0, 4'd0, 4'd1, 64'h55, 64'h0);
    chk("popq_w2_en", 64'(wr_en), 64'd1);
    chk("popq_w2", {wr_addr, wr_data[59:0]}, {4'd7, 60'hABCD});
    step(1'b1, 4'h3, 1'b0, 4'd0, 4'd1, 64'h55, 64'h0);
    chk("after_popq", {wr_addr, wr_data[59:0]}, {4'd1, 60'h55});

    // popq into %rsp itself: load value wins.
    step(1'b1, 4'hB, 1'b0, 4'd4, 4'd0, 64'h2000, 64'h5555);
    idle();
    chk("popq_rsp_final", {wr_addr, wr_data[59:0]}, {4'd4, 60'h5555});

    // halt is sticky and blocks further traffic.
    step(1'b1, 4'h0, 1'b0, 4'd0, 4'd0, 64'h0, 64'h0);
    chk("halt_set", 64'(halted), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 4'h3, 1'b0, 4'd0, 4'd2, 64'hDEAD, 64'h0);
    chk("halt_ready", 64'(in_ready), 64'd0);
    do_reset();

    step(1'b1, 4'hE, 1'b0, 4'd0, 4'd0, 64'h0, 64'h0);
    chk("err_set", 64'(instr_err), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 4'h6, 1'b0, 4'd0, 4'd3, 64'hBEEF, 64'h0);
    do_reset();

    // Reset mid-cycle while the second popq write is pending.
    step(1'b1, 4'h3, 1'b0, 4'd0, 4'd2, 64'h11, 64'h0);
    step(1'b1, 4'hB, 1'b0, 4'd7, 4'd0, 64'h1008, 64'hABCD);
    chk("pre_rst_w1", 64'(wr_en), 64'd1);
    do_reset();
    chk("post_rst_no_w2", 64'(wr_en), 64'd0);
    chk("post_rst_idle", 64'(in_ready), 64'd1);
    idle();
    idle();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0 || ((mh || me) && $urandom_range(0, 7) == 0)) do_reset();
      rv  = ($urandom_range(0, 3) != 0);
      ric = 4'($urandom_range(0, 15));
      if ((ric == 4'h0 || ric >= 4'hC) && $urandom_range(0, 29) != 0) ric = 4'($urandom_range(1, 11));
      rcn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: rra = 4'd4;
        1: rra = 4'd15;
        default: rra = 4'($urandom_range(0, 15));
      endcase
      rrb = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      rve = {$urandom, $urandom};
      rvm = {$urandom, $urandom};
      step(rv, ric, rcn, rra, rrb, rve, rvm);
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
